seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 100000; clk cycles each digit stays enabled (legal 2..2^20).
REQ-002 SHALL provide `clk  input  1`: system clock, all state on rising edge.
REQ-003 SHALL provide `rst  input  1`: reset, asynchronous, active-low.
REQ-004 SHALL provide `load  input  1`: one-cycle request to capture value and aux.
REQ-005 SHALL provide `value  input  12`: signed two's-complement balance, range -2048..2047.
REQ-006 SHALL provide `aux  input  12`: three hex nibbles for the left group, such as mode or timer.
REQ-007 SHALL provide `busy  output  1`: high while a conversion is in progress.
REQ-008 SHALL provide `ena_r  output  4`: right-group digit enables; active-high, one-hot, bit0 = rightmost digit.
REQ-009 SHALL provide `ena_l  output  4`: left-group digit enables, same format as ena_r.
REQ-010 SHALL provide `seg_r  output  8`: right-group segments {a,b,c,d,e,f,g,dp}; bit7 = a; active-high.
REQ-011 SHALL provide `seg_l  output  8`: left-group segments, same format as seg_r.

Function
REQ-012 Load handshake: a load sampled with busy=0 SHALL capture value and aux; a load sampled with busy=1 SHALL be ignored with no queuing.
REQ-013 Sign/magnitude: magnitude = |value| as a 12-bit unsigned number (-2048 -> 2048); a sign flag SHALL be registered at capture.
REQ-014 BCD conversion: shift-add-3 (double-dabble), one bit per cycle, 12 iterations.
REQ-015 Conversion timing: for a load accepted at edge N, busy SHALL be 1 for edges N+1..N+12, and new BCD, sign and aux SHALL become visible at edge N+13 with busy=0.
REQ-016 Display hold: displayed data SHALL hold its previous contents until the conversion completes, with no partial digits shown.
REQ-017 Scan FSM: a free-running counter SHALL count 0..SCAN_DIV-1; on wrap, digit index idx 0..3 SHALL increment, wrapping 3->0.
REQ-018 Scan continuity: scanning SHALL continue independent of busy.
REQ-019 Enables: ena_r = ena_l = one-hot(idx), both registered; both groups SHALL scan the same index simultaneously.
REQ-020 seg_r[idx] SHALL show BCD digit idx of the magnitude (idx0 = ones).
REQ-021 seg_l idx0..2 SHALL show aux nibble idx as hex 0-F.
REQ-022 seg_l idx3 SHALL show '-' (00000010) if the sign flag = 1, else blank (00000000).
REQ-023 Glyph table: 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110, 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11110110, A=11101110, b=00111110, C=10011100, d=01111010, E=10011110, F=10001110.
REQ-024 dp SHALL always be 0.
REQ-025 seg outputs SHALL be registered and aligned with ena in the same cycle (no ghosting between digits).
REQ-026 If load coincides with scan wrap, both SHALL take effect independently.
REQ-027 Magnitude 0 SHALL display '0' on right idx0.

Reset
REQ-028 On rst=0, immediately and asynchronously: ena_r=ena_l=0000, seg_r=seg_l=00000000, busy=0, idx=0, counter=0, BCD=0, sign=0, aux register=0.
REQ-029 The first clk edge after rst release SHALL drive ena=0001 and the corresponding segments.
REQ-030 Reset during a conversion SHALL abort it; no result SHALL be committed.

Configuration
REQ-031 With macro SEG_LEADING_ZERO_BLANK_EN defined, right-group digits above the most significant nonzero digit SHALL be blank (00000000); idx0 SHALL never be blanked.
REQ-032 Without SEG_LEADING_ZERO_BLANK_EN, all four right digits SHALL always show a numeral, including leading zeros.

Verification
REQ-033 Reset release with SCAN_DIV=4 -> ena_r: 0001 for 4 cycles, then 0010, 0100, 1000, 0001; seg_r at idx0 = 11111100.
REQ-034 load, value=1234, aux=0x3A5 -> busy high exactly 12 cycles; then right shows 1,2,3,4 (idx3..0), left shows blank,3,A,5.
REQ-035 load, value=-2048 -> right shows 2,0,4,8; left idx3 = 00000010.
REQ-036 load 1234, then load 999 two cycles later -> second load ignored; final display 1234; busy never extended.
REQ-037 value=7 -> with SEG_LEADING_ZERO_BLANK_EN: blank,blank,blank,7; without it: 0,0,0,7.
REQ-038 rst asserted at busy cycle 6 of a conversion -> all outputs 0 immediately; after release, display shows 0 and busy=0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//
// Drives two multiplexed 4-digit seven-segment groups from a single scan.
// The right group shows the decimal magnitude of a signed 12-bit value,
// converted by a serial shift-add-3 (double-dabble) engine. The left group
// shows three hex nibbles of an auxiliary word plus a minus sign.
//
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank right-group
// digits above the most significant nonzero digit (the ones digit is never
// blanked). Without it all four right digits always show a numeral.
//
// Parameters:
//   SCAN_DIV  clk cycles each digit stays enabled (2..2^20)
//
// Ports:
//   clk    system clock, all state on rising edge
//   rst    asynchronous, active-low reset
//   load   one-cycle request to capture value and aux (ignored while busy)
//   value  signed two's-complement number, -2048..2047
//   aux    three hex nibbles for left digits 0..2
//   busy   high while a conversion is in progress
//   ena_r  right-group digit enables, one-hot, bit0 = rightmost
//   ena_l  left-group digit enables, same index as ena_r
//   seg_r  right-group segments {a,b,c,d,e,f,g,dp}, active-high
//   seg_l  left-group segments, same format

module seg_scan_driver #(
   parameter int SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [11:0] value,
   input  logic [11:0] aux,
   output logic        busy,
   output logic [3:0]  ena_r,
   output logic [3:0]  ena_l,
   output logic [7:0]  seg_r,
   output logic [7:0]  seg_l
);

   localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);

   logic [19:0] scan_cnt;
   logic [1:0]  idx;

   logic [11:0] bin_sh;
   logic [15:0] bcd_work;
   logic [15:0] bcd_adj;
   logic [15:0] bcd_next;
   logic [3:0]  bit_cnt;
   logic        sign_pend;
   logic [11:0] aux_pend;

   logic [15:0] bcd_disp;
   logic        sign_disp;
   logic [11:0] aux_disp;

   logic [11:0] mag;
   logic [3:0]  digit_r;
   logic [3:0]  nib_l;
   logic        blank_r;
   logic [7:0]  seg_r_next;
   logic [7:0]  seg_l_next;

   // Glyph lookup shared by both groups; dp bit is always 0.
   function automatic logic [7:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 8'b11111100;
         4'h1: glyph = 8'b01100000;
         4'h2: glyph = 8'b11011010;
         4'h3: glyph = 8'b11110010;
         4'h4: glyph = 8'b01100110;
         4'h5: glyph = 8'b10110110;
         4'h6: glyph = 8'b10111110;
         4'h7: glyph = 8'b11100000;
         4'h8: glyph = 8'b11111110;
         4'h9: glyph = 8'b11110110;
         4'hA: glyph = 8'b11101110;
         4'hB: glyph = 8'b00111110;
         4'hC: glyph = 8'b10011100;
         4'hD: glyph = 8'b01111010;
         4'hE: glyph = 8'b10011110;
         default: glyph = 8'b10001110;
      endcase
   endfunction

   // Absolute value; -2048 wraps to 0x800, which reads as 2048 unsigned.
   always_comb begin
      mag = value[11] ? (~value + 12'd1) : value;
   end

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift in
   // the next binary bit from the top of the shift register.
   always_comb begin
      bcd_adj = bcd_work;
      for (int i = 0; i < 4; i++) begin
         if (bcd_work[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd_work[i*4 +: 4] + 4'd3;
         end
      end
      bcd_next = {bcd_adj[14:0], bin_sh[11]};
   end

   // Conversion engine. A load seen while idle arms 12 shift steps; the final
   // step commits BCD, sign and aux together so the display never sees a
   // partially converted number.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy      <= 1'b0;
         bin_sh    <= '0;
         bcd_work  <= '0;
         bit_cnt   <= '0;
         sign_pend <= 1'b0;
         aux_pend  <= '0;
         bcd_disp  <= '0;
         sign_disp <= 1'b0;
         aux_disp  <= '0;
      end else if (busy) begin
         bin_sh   <= {bin_sh[10:0], 1'b0};
         bcd_work <= bcd_next;
         bit_cnt  <= bit_cnt - 4'd1;
         if (bit_cnt == 4'd1) begin
            busy      <= 1'b0;
            bcd_disp  <= bcd_next;
            sign_disp <= sign_pend;
            aux_disp  <= aux_pend;
         end
      end else if (load) begin
         busy      <= 1'b1;
         bin_sh    <= mag;
         bcd_work  <= '0;
         bit_cnt   <= 4'd12;
         sign_pend <= value[11];
         aux_pend  <= aux;
      end
   end

   // Free-running scan divider and digit index, unaffected by conversions.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         idx      <= idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + 20'd1;
      end
   end

   // Select the digit for the current index. Leading-zero blanking looks at
   // the current digit and every digit above it.
   always_comb begin
      digit_r = bcd_disp[idx*4 +: 4];
      nib_l   = aux_disp[idx*4 +: 4];
      blank_r = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      case (idx)
         2'd3:    blank_r = (bcd_disp[15:12] == 4'd0);
         2'd2:    blank_r = (bcd_disp[15:8]  == 8'd0);
         2'd1:    blank_r = (bcd_disp[15:4]  == 12'd0);
         default: blank_r = 1'b0;
      endcase
`endif
      seg_r_next = blank_r ? 8'b00000000 : glyph(digit_r);
      if (idx == 2'd3) begin
         seg_l_next = sign_disp ? 8'b00000010 : 8'b00000000;
      end else begin
         seg_l_next = glyph(nib_l);
      end
   end

   // Enables and segments are registered together from the same index so
   // the digit drive never straddles two digits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ena_r <= '0;
         ena_l <= '0;
         seg_r <= '0;
         seg_l <= '0;
      end else begin
         ena_r <= 4'b0001 << idx;
         ena_l <= 4'b0001 << idx;
         seg_r <= seg_r_next;
         seg_l <= seg_l_next;
      end
   end

endmodule
